// File: rtl/sirius_pkg.sv
// Shared definitions for the Sirius register file: default geometry, clear-FSM
// state encoding and the constants for the hard-wired zero register.
package sirius_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Index of the register that always reads as zero and ignores writes.
    localparam int ZERO_REG = 0;
    // Sliced down to the actual register width where it is used.
    localparam logic [1023:0] ZERO_WORD = '0;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks register indices 1..DEPTH-1, one per cycle,
// and tells the array which entry to zero.
module regfile_clr_fsm
    import sirius_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    clr_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= CLR_IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        clr_busy   = 1'b0;
        clr_done   = 1'b0;
        clr_en     = 1'b0;
        clr_idx    = idx_reg;
        case (state_reg)
            CLR_IDLE: begin
                // Register 0 needs no clearing, so the sweep starts at 1.
                if (clr_req) begin
                    state_next = CLR_SWEEP;
                    idx_next   = ADDR_W'(1);
                end
            end
            CLR_SWEEP: begin
                clr_busy = 1'b1;
                clr_en   = 1'b1;
                if (idx_reg == LAST_IDX) begin
                    clr_done   = 1'b1;
                    state_next = CLR_IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + ADDR_W'(1);
                end
            end
            default: state_next = CLR_IDLE;
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, per-register pending scoreboard
// and a sequential clear sweep that blanks all ports while it runs.
module regfile_mp
    import sirius_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rpend,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam logic [DATA_W-1:0] ZERO_DATA = ZERO_WORD[DATA_W-1:0];

    logic [DATA_W-1:0] mem_reg  [DEPTH];
    logic [DATA_W-1:0] mem_next [DEPTH];
    logic [DEPTH-1:0]  pend_reg, pend_next;

    logic [NUM_WR-1:0] we_eff;
    logic              iss_fire;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_idx;

    regfile_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_en   (clr_en),
        .clr_idx  (clr_idx)
    );

    // The sweep owns the array: writes and issues are dropped, not stalled.
    assign we_eff    = clr_busy ? '0 : we;
    assign iss_ready = ~clr_busy;
    assign iss_fire  = iss_valid & iss_ready & (iss_addr != ZERO_ADDR);

    // Per-address resolve; later ports overwrite earlier ones, so the highest
    // index wins. Issue is applied last so a new producer beats a retire.
    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            mem_next[a]  = mem_reg[a];
            pend_next[a] = pend_reg[a];
            for (int k = 0; k < NUM_WR; k++) begin
                if (we_eff[k] && (waddr[k*ADDR_W +: ADDR_W] == ADDR_W'(a))) begin
                    mem_next[a]  = wdata[k*DATA_W +: DATA_W];
                    pend_next[a] = 1'b0;
                end
            end
            if (clr_en && (clr_idx == ADDR_W'(a))) begin
                mem_next[a]  = ZERO_DATA;
                pend_next[a] = 1'b0;
            end
            if (iss_fire && (iss_addr == ADDR_W'(a))) begin
                pend_next[a] = 1'b1;
            end
        end
        mem_next[ZERO_REG]  = ZERO_DATA;
        pend_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_reg[a] <= '0;
            end
            pend_reg <= '0;
        end else begin
            mem_reg  <= mem_next;
            pend_reg <= pend_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] word;
            logic              pend;

            assign addr = raddr[gi*ADDR_W +: ADDR_W];

            // Pending is read from the stored bit only; a same-cycle retire
            // becomes visible after the edge.
            always_comb begin
                word = ZERO_DATA;
                pend = 1'b0;
                if (!clr_busy && re[gi] && (addr != ZERO_ADDR)) begin
                    word = mem_reg[addr];
                    pend = pend_reg[addr];
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (we_eff[k] && (waddr[k*ADDR_W +: ADDR_W] == addr)) begin
                            word = wdata[k*DATA_W +: DATA_W];
                        end
                    end
                end
            end

            assign rdata[gi*DATA_W +: DATA_W] = word;
            assign rpend[gi]                  = pend;
        end
    endgenerate

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the Sirius pipeline. It replaces the fixed 2-read/1-write file with configurable width, depth and read/write port counts, plus same-cycle write bypass. It adds a per-register pending scoreboard for the issue stage and a sequential clear engine used on exception or context restart. It sits between decode (reads, issue), writeback (writes, retire) and the control unit (clear).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W; register 0 is hard-wired zero
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- we  in  NUM_WR  per-port write enable
- waddr  in  NUM_WR*ADDR_W  packed write addresses, port k at [k*ADDR_W +: ADDR_W]
- wdata  in  NUM_WR*DATA_W  packed write data
- re  in  NUM_RD  per-port read enable
- raddr  in  NUM_RD*ADDR_W  packed read addresses
- rdata  out  NUM_RD*DATA_W  packed read data, combinational
- rpend  out  NUM_RD  pending bit of the register addressed by each read port
- iss_valid  in  1  issue: mark iss_addr pending
- iss_addr  in  ADDR_W  destination of the issued instruction
- iss_ready  out  1  issue accepted (low while clearing)
- clr_req  in  1  start clear sweep (single-cycle pulse)
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse on the final sweep cycle

## Operation
- Reset (rst=0): every register, every pending bit and the FSM are cleared immediately; state IDLE; rdata=0, rpend=0, clr_busy=0, clr_done=0, iss_ready=1.
- Write: port k with we[k]=1 and waddr≠0 writes wdata at the posedge and clears pending[waddr] (retire). Writes to address 0 are discarded. When several ports hit the same address in one cycle, the highest-index port wins.
- Read port j: rdata is 0 if re[j]=0 or raddr=0. Otherwise it bypasses from the highest-index port with we=1 and a matching address (nonzero). Otherwise it returns the array value.
- rpend[j] = pending[raddr[j]] & re[j]. rpend is 0 for address 0. rpend does not reflect same-cycle retire, which lands at the edge.
- Issue: iss_valid & iss_ready & iss_addr≠0 sets pending[iss_addr] at the posedge. If the same address is retired and issued in one cycle, set wins, because the new producer supersedes the old one.
- Clear FSM, states IDLE and SWEEP:
  - IDLE→SWEEP on clr_req; the index counter loads 1.
  - In SWEEP, each cycle zeroes register idx and pending[idx], then increments idx.
  - On idx=DEPTH-1: clr_done=1 and the FSM returns to IDLE on the next edge.
  - SWEEP lasts exactly DEPTH-1 cycles (31 at defaults).
  - clr_req in SWEEP is ignored; the sweep is not restarted.
- While clr_busy=1:
  - all we and iss_valid are dropped;
  - iss_ready=0;
  - rdata=0 and rpend=0 on every port.
- Reset asserted mid-sweep aborts it immediately. There is no clr_done pulse and the FSM is in IDLE on release.

## Timing
- Read latency 0, combinational from raddr/re/we/waddr/wdata.
- Write, retire and issue take effect at the next posedge. They are visible in the array one cycle after, and visible immediately via bypass.
- clr_busy rises the cycle after clr_req is sampled and falls DEPTH-1 cycles later. clr_done coincides with the last busy cycle.
- First normal write is accepted on the cycle clr_busy is low again.

## Structure
- Shared package (sirius_pkg): default DATA_W/ADDR_W, the FSM state enum (CLR_IDLE, CLR_SWEEP), and the zero-word and zero-register constants.
- Sub-module regfile_clr_fsm holds the state, index counter and busy/done outputs. It emits a clear-enable and a clear-index to the array.
- Read-port logic is a generate loop per port. The write-priority resolve is a per-address highest-index loop.

## Test plan
- Reset/zero: release rst, write 0xDEADBEEF to r0 via port 0, read r0 → rdata=0, rpend=0.
- Bypass and priority: same cycle, port0 writes r5=0x11 and port1 writes r5=0x22, read r5 → rdata=0x22 that cycle and 0x22 after the edge.
- Scoreboard: issue r7 → rpend=1 next cycle. Retire r7 with 0x55 → rpend=0 and rdata=0x55. Then issue and retire r7 in the same cycle → rpend stays 1.
- Clear sweep (defaults): load r1..r31 with nonzero values and pending bits, pulse clr_req. Expect:
  - clr_busy high for exactly 31 cycles;
  - clr_done on the 31st busy cycle;
  - writes and issues dropped during the sweep, with iss_ready=0;
  - all reads 0 and all rpend 0 afterwards.
- Reset mid-sweep: assert rst at sweep cycle 10 → clr_busy=0 immediately, no clr_done, all registers 0.
- Parameter sweep: NUM_RD=4, NUM_WR=3, DATA_W=64, ADDR_W=6 → random writes/reads checked against a reference model; sweep length 63 cycles.
